uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Framed command decoder between the command-channel uart_receiver and the LED display control path (led_driver roll/brightness inputs).
- Consumes received bytes, validates 4-byte packets and applies roll mode and brightness level.
- Merges in debounced brightness button steps.
- Returns a one-byte ACK/NAK through a valid/ready handshake towards a UART transmitter.

Parameters:
- TIMEOUT_CYCLES, 500000, max idle clk cycles between bytes of one packet (10 ms at 50 MHz).
- HEADER, 8'hA5, packet start byte.
- ACK_BYTE, 8'h06, response to an accepted packet.
- NAK_BYTE, 8'h15, response to a rejected packet.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- bright_step  in  1  one-cycle pulse from the debounced brightness button
- roll_mode  out  2  00 static, 01 right, 10 left, 11 reset-position
- bright_level  out  2  brightness level 0..3
- cmd_strobe  out  1  one-cycle pulse when an accepted packet updates a register
- tx_data  out  8  response byte
- tx_valid  out  1  response pending
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready
- err_cnt  out  8  saturating count of rejected/timed-out/dropped packets

Behaviour:
- Reset values: roll_mode=00, bright_level=00, cmd_strobe=0, tx_valid=0, tx_data=00, err_cnt=0, FSM=IDLE, timeout counter=0.
- Packet format: HEADER, CMD, ARG, CHK, where CHK = CMD ^ ARG.
- Commands:
  - CMD 01: roll_mode <= ARG[1:0].
  - CMD 02: bright_level <= ARG[1:0].
  - CMD 03: query, no register change; response is {4'h0, roll_mode, bright_level} instead of ACK.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK, RESP.
  - IDLE: rx_valid with rx_data==HEADER -> GET_CMD. Any other byte is discarded silently; err_cnt is not incremented.
  - GET_CMD: capture the byte -> GET_ARG.
  - GET_ARG: capture the byte -> GET_CHK.
  - GET_CHK: on rx_valid, evaluate the packet and go to RESP. Packet is valid iff CHK matches, CMD is in {01,02,03} and ARG[7:2]==0.
    - Valid: apply the update and pulse cmd_strobe for one cycle, both in the cycle after the CHK byte. Pulse cmd_strobe for CMD 01/02 only.
    - Invalid: no register change, err_cnt+1.
  - Latency: tx_valid rises exactly 1 cycle after the CHK byte's rx_valid cycle.
  - RESP: hold tx_valid and tx_data stable until tx_valid&tx_ready. In that handshake cycle, deassert tx_valid on the next edge and return to IDLE.
  - rx_valid during RESP: byte dropped, err_cnt+1. A HEADER byte received in RESP is not retained.
- Timeout: counter clears on every rx_valid and counts in GET_CMD/GET_ARG/GET_CHK. When it reaches TIMEOUT_CYCLES -> IDLE, err_cnt+1, no response. Counter is held at 0 in IDLE/RESP. Width is $clog2(TIMEOUT_CYCLES+1).
- bright_step: bright_level increments modulo 4 (3 -> 0) in any FSM state.
  - If a valid CMD 02 update occurs in the same cycle, the UART value wins and the step is discarded.
  - bright_step never affects roll_mode.
- err_cnt saturates at 8'hFF.
- rst_n low mid-packet or mid-RESP: everything returns to reset values on the next edge. A pending response is abandoned.

Decomposition:
- Shared defines header holds HEADER/ACK/NAK byte values, command codes (CMD_ROLL=01, CMD_BRIGHT=02, CMD_QUERY=03), the roll_mode encodings and the FSM state encodings.
- One natural sub-module: cmd_timeout_timer (clear, enable, expired pulse), reusable by frame_buffer receive logic.
- Checksum and command validation stay inline.

Test Plan:
- Send A5 02 03 01 with tx_ready=1 -> bright_level=3 one cycle after the CHK byte, cmd_strobe pulse, tx_data=06, err_cnt=0.
- Send A5 01 02 03, then A5 03 00 03 -> roll_mode=10, then query response tx_data=8'h0B (roll 10, bright 11 from the prior test or the current level).
- Send A5 02 01 00 (bad CHK) and A5 07 00 07 (bad CMD) -> bright_level unchanged, two NAK 15 responses, err_cnt=2.
- Send A5 02, then idle TIMEOUT_CYCLES+2 cycles, then A5 02 02 00 -> first packet dropped with no tx_valid and err_cnt+1; second packet sets bright_level=2 with ACK.
- bright_step pulses from level 3 -> 0; bright_step coincident with a valid CMD 02 ARG=1 update cycle -> bright_level=1.
- Hold tx_ready=0 for 20 cycles after a valid packet -> tx_valid/tx_data stable; a byte arriving meanwhile increments err_cnt. Assert rst_n=0 during GET_ARG -> all outputs at reset values next edge.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: framing bytes, command codes,
// roll-mode encodings and the packet FSM state encoding.
package uart_cmd_parser_pkg;

    localparam logic [7:0] PKT_HEADER = 8'hA5;
    localparam logic [7:0] ACK_CODE   = 8'h06;
    localparam logic [7:0] NAK_CODE   = 8'h15;

    localparam logic [7:0] CMD_ROLL   = 8'h01;
    localparam logic [7:0] CMD_BRIGHT = 8'h02;
    localparam logic [7:0] CMD_QUERY  = 8'h03;

    localparam logic [1:0] ROLL_STATIC = 2'b00;
    localparam logic [1:0] ROLL_RIGHT  = 2'b01;
    localparam logic [1:0] ROLL_LEFT   = 2'b10;
    localparam logic [1:0] ROLL_HOME   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CMD = 3'd1,
        ST_GET_ARG = 3'd2,
        ST_GET_CHK = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in from the UART receiver and the ACK/NAK handshake out to the
// transmitter. The slave modport is the parser, the master modport its environment.
interface uart_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

endinterface

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and flags
// expiry once LIMIT cycles have elapsed.
module uart_cmd_parser_timeout #(
    parameter int unsigned LIMIT = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned       CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_r;

    // Idle counter; parks at LIMIT so expiry stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LIMIT_C)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable & ~clear & (count_r == LIMIT_C);

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed UART command decoder: validates HEADER/CMD/ARG/CHK packets, drives the
// LED roll/brightness registers and answers each packet with ACK, NAK or status.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [7:0]  HEADER         = PKT_HEADER,
    parameter logic [7:0]  ACK_BYTE       = ACK_CODE,
    parameter logic [7:0]  NAK_BYTE       = NAK_CODE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_cmd_parser_if.slave       bus,
    input  logic                   bright_step,
    output logic [1:0]             roll_mode,
    output logic [1:0]             bright_level,
    output logic                   cmd_strobe,
    output logic [7:0]             err_cnt
);

    // Checksum and command-field validation of a complete packet.
    function automatic logic pkt_ok(input logic [7:0] cmd,
                                    input logic [7:0] arg,
                                    input logic [7:0] chk);
        logic cmd_known;
        cmd_known = (cmd == CMD_ROLL) || (cmd == CMD_BRIGHT) || (cmd == CMD_QUERY);
        return (chk == (cmd ^ arg)) && (arg[7:2] == 6'd0) && cmd_known;
    endfunction

    state_t     state_r;
    state_t     state_nx;
    logic [7:0] cmd_r;
    logic [7:0] arg_r;
    logic [1:0] roll_r;
    logic [1:0] bright_r;
    logic       strobe_r;
    logic       tx_valid_r;
    logic [7:0] tx_data_r;
    logic [7:0] err_r;

    logic [1:0] roll_nx;
    logic [1:0] bright_nx;
    logic       strobe_nx;
    logic       tx_valid_nx;
    logic [7:0] tx_data_nx;
    logic       err_inc;

    logic       in_packet_s;
    logic       tmo_clear_s;
    logic       tmo_expired_s;
    logic       tx_fire_s;

    assign in_packet_s = (state_r == ST_GET_CMD) || (state_r == ST_GET_ARG) ||
                         (state_r == ST_GET_CHK);
    assign tmo_clear_s = bus.rx_valid | ~in_packet_s;
    assign tx_fire_s   = tx_valid_r & bus.tx_ready;

    uart_cmd_parser_timeout #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear_s),
        .enable  (in_packet_s),
        .expired (tmo_expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic; a received byte always takes priority over expiry.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == HEADER)) state_nx = ST_GET_CMD;
                else                                         state_nx = ST_IDLE;
            end
            ST_GET_CMD: begin
                if (bus.rx_valid)       state_nx = ST_GET_ARG;
                else if (tmo_expired_s) state_nx = ST_IDLE;
                else                    state_nx = ST_GET_CMD;
            end
            ST_GET_ARG: begin
                if (bus.rx_valid)       state_nx = ST_GET_CHK;
                else if (tmo_expired_s) state_nx = ST_IDLE;
                else                    state_nx = ST_GET_ARG;
            end
            ST_GET_CHK: begin
                if (bus.rx_valid)       state_nx = ST_RESP;
                else if (tmo_expired_s) state_nx = ST_IDLE;
                else                    state_nx = ST_GET_CHK;
            end
            ST_RESP: begin
                if (tx_fire_s) state_nx = ST_IDLE;
                else           state_nx = ST_RESP;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        roll_nx     = roll_r;
        strobe_nx   = 1'b0;
        tx_valid_nx = tx_valid_r;
        tx_data_nx  = tx_data_r;
        err_inc     = 1'b0;
        if (bright_step) bright_nx = bright_r + 2'd1;
        else             bright_nx = bright_r;

        case (state_r)
            ST_GET_CMD, ST_GET_ARG: begin
                if (tmo_expired_s) err_inc = 1'b1;
                else               err_inc = 1'b0;
            end
            ST_GET_CHK: begin
                if (bus.rx_valid) begin
                    tx_valid_nx = 1'b1;
                    if (pkt_ok(cmd_r, arg_r, bus.rx_data)) begin
                        case (cmd_r)
                            CMD_ROLL: begin
                                roll_nx    = arg_r[1:0];
                                strobe_nx  = 1'b1;
                                tx_data_nx = ACK_BYTE;
                            end
                            CMD_BRIGHT: begin
                                // The UART value overrides a coincident button step.
                                bright_nx  = arg_r[1:0];
                                strobe_nx  = 1'b1;
                                tx_data_nx = ACK_BYTE;
                            end
                            CMD_QUERY: tx_data_nx = {4'h0, roll_r, bright_r};
                            default:   tx_data_nx = NAK_BYTE;
                        endcase
                    end else begin
                        tx_data_nx = NAK_BYTE;
                        err_inc    = 1'b1;
                    end
                end else if (tmo_expired_s) begin
                    err_inc = 1'b1;
                end else begin
                    err_inc = 1'b0;
                end
            end
            ST_RESP: begin
                if (bus.rx_valid) err_inc = 1'b1;
                else              err_inc = 1'b0;
                if (tx_fire_s) tx_valid_nx = 1'b0;
                else           tx_valid_nx = tx_valid_r;
            end
            default: err_inc = 1'b0;
        endcase
    end

    // Output, capture and error-count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_r      <= 8'h00;
            arg_r      <= 8'h00;
            roll_r     <= ROLL_STATIC;
            bright_r   <= 2'd0;
            strobe_r   <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            err_r      <= 8'h00;
        end else begin
            if ((state_r == ST_GET_CMD) && bus.rx_valid) cmd_r <= bus.rx_data;
            if ((state_r == ST_GET_ARG) && bus.rx_valid) arg_r <= bus.rx_data;
            roll_r     <= roll_nx;
            bright_r   <= bright_nx;
            strobe_r   <= strobe_nx;
            tx_valid_r <= tx_valid_nx;
            tx_data_r  <= tx_data_nx;
            if (err_inc && (err_r != 8'hFF)) err_r <= err_r + 8'd1;
        end
    end

    assign roll_mode    = roll_r;
    assign bright_level = bright_r;
    assign cmd_strobe   = strobe_r;
    assign err_cnt      = err_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_valid = tx_valid_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; expected response bytes go into a queue
// and a monitor compares them at every tx handshake.
module tb_uart_cmd_parser;

    localparam int unsigned TMO = 40;

    logic       clk;
    logic       rst_n;
    logic       bright_step;
    logic [1:0] roll_mode;
    logic [1:0] bright_level;
    logic       cmd_strobe;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .bright_step  (bright_step),
        .roll_mode    (roll_mode),
        .bright_level (bright_level),
        .cmd_strobe   (cmd_strobe),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(k);
    endtask

    // Response monitor: every handshake must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("resp_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bright_step  = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        tick(3);
        check("rst_roll", {30'h0, roll_mode}, 32'd0);
        check("rst_bright", {30'h0, bright_level}, 32'd0);
        check("rst_strobe", {31'h0, cmd_strobe}, 32'd0);
        check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h00);
        check("rst_err", {24'h0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        bus.tx_ready = 1'b1;
        tick(1);

        // Brightness write, then roll write and status query.
        exp_q.push_back(8'h06);
        send_pkt(8'h02, 8'h03, 8'h01);
        check("t1_bright", {30'h0, bright_level}, 32'd3);
        check("t1_strobe", {31'h0, cmd_strobe}, 32'd1);
        check("t1_tx_valid", {31'h0, bus.tx_valid}, 32'd1);
        check("t1_err", {24'h0, err_cnt}, 32'd0);
        tick(1);
        check("t1_strobe_pulse", {31'h0, cmd_strobe}, 32'd0);
        check("t1_tx_done", {31'h0, bus.tx_valid}, 32'd0);

        exp_q.push_back(8'h06);
        send_pkt(8'h01, 8'h02, 8'h03);
        check("t2_roll", {30'h0, roll_mode}, 32'd2);
        check("t2_strobe", {31'h0, cmd_strobe}, 32'd1);
        tick(1);
        exp_q.push_back(8'h0B);
        send_pkt(8'h03, 8'h00, 8'h03);
        check("t2_query_nostrobe", {31'h0, cmd_strobe}, 32'd0);
        check("t2_query_roll", {30'h0, roll_mode}, 32'd2);
        tick(1);

        // Rejected packets: bad checksum, unknown command, oversize argument.
        exp_q.push_back(8'h15);
        send_pkt(8'h02, 8'h01, 8'h00);
        check("t3_bright_kept", {30'h0, bright_level}, 32'd3);
        check("t3_nak_nostrobe", {31'h0, cmd_strobe}, 32'd0);
        tick(1);
        exp_q.push_back(8'h15);
        send_pkt(8'h07, 8'h00, 8'h07);
        check("t3_err2", {24'h0, err_cnt}, 32'd2);
        tick(1);
        exp_q.push_back(8'h15);
        send_pkt(8'h01, 8'h04, 8'h05);
        check("t3_arg_roll_kept", {30'h0, roll_mode}, 32'd2);
        check("t3_err3", {24'h0, err_cnt}, 32'd3);
        tick(1);

        // Inter-byte timeout abandons the packet silently.
        send_byte(8'hA5);
        send_byte(8'h02);
        tick(TMO + 2);
        check("t4_no_resp", {31'h0, bus.tx_valid}, 32'd0);
        check("t4_err", {24'h0, err_cnt}, 32'd4);
        exp_q.push_back(8'h06);
        send_pkt(8'h02, 8'h02, 8'h00);
        check("t4_bright", {30'h0, bright_level}, 32'd2);
        tick(1);

        // Button steps with wrap, then a step colliding with a UART write.
        for (int i = 0; i < 4; i++) begin
            bright_step = 1'b1;
            tick(1);
            bright_step = 1'b0;
            check("t5_step", {30'h0, bright_level}, (32'd3 + i) % 32'd4);
        end
        check("t5_roll_kept", {30'h0, roll_mode}, 32'd2);
        exp_q.push_back(8'h06);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        bright_step = 1'b1;
        send_byte(8'h03);
        bright_step = 1'b0;
        check("t5_uart_wins", {30'h0, bright_level}, 32'd1);
        tick(1);

        // Back-pressure: response held, bytes during RESP dropped and counted.
        bus.tx_ready = 1'b0;
        exp_q.push_back(8'h06);
        send_pkt(8'h01, 8'h01, 8'h00);
        check("t6_roll", {30'h0, roll_mode}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(8'hA5);
            else        tick(1);
            check("t6_hold_valid", {31'h0, bus.tx_valid}, 32'd1);
            check("t6_hold_data", {24'h0, bus.tx_data}, 32'h06);
        end
        check("t6_err_drop", {24'h0, err_cnt}, 32'd5);
        bus.tx_ready = 1'b1;
        tick(1);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h01);
        tick(1);
        check("t6_hdr_not_kept", {30'h0, bright_level}, 32'd1);
        check("t6_no_resp", {31'h0, bus.tx_valid}, 32'd0);
        check("t6_err_same", {24'h0, err_cnt}, 32'd5);

        // Reset mid-packet and with a response pending.
        send_byte(8'hA5);
        send_byte(8'h01);
        rst_n = 1'b0;
        tick(1);
        check("t7_rst_roll", {30'h0, roll_mode}, 32'd0);
        check("t7_rst_bright", {30'h0, bright_level}, 32'd0);
        check("t7_rst_err", {24'h0, err_cnt}, 32'd0);
        check("t7_rst_tx_data", {24'h0, bus.tx_data}, 32'h00);
        rst_n = 1'b1;
        bus.tx_ready = 1'b0;
        tick(1);
        send_pkt(8'h02, 8'h01, 8'h03);
        check("t7_pend_valid", {31'h0, bus.tx_valid}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("t7_abandon", {31'h0, bus.tx_valid}, 32'd0);
        check("t7_abandon_bright", {30'h0, bright_level}, 32'd0);
        rst_n = 1'b1;
        bus.tx_ready = 1'b1;
        tick(1);
        exp_q.push_back(8'h00);
        send_pkt(8'h03, 8'h00, 8'h03);
        tick(3);
        check("all_resp_seen", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
